// File: rtl/l1tol2_req_arb.sv
// Merges icache and dcache L1 request streams into the single L2 request pipe.
// Each source is buffered in its own FIFO; a round-robin arbiter loads a registered output stage.

module l1tol2_req_arb_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_valid,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [DATA_BITS-1:0] head_data
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [CNT_BITS-1:0]  count;
    logic                 push_en;
    logic                 pop_en;

    // Full is decided from registered state only, so a pop in the same cycle never frees a slot early.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push_en   = push_valid && !full;
    assign pop_en    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + CNT_BITS'(push_en) - CNT_BITS'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module l1tol2_req_arb #(
    parameter int FIFO_DEPTH  = 2,
    parameter int DCID_BITS   = 5,
    parameter int CMD_BITS    = 4,
    parameter int PCSIGN_BITS = 13,
    parameter int LADDR_BITS  = 39,
    parameter int SPTBR_BITS  = 38
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_retry,
    input  logic [DCID_BITS-1:0]   ic_req_dcid,
    input  logic [CMD_BITS-1:0]    ic_req_cmd,
    input  logic [PCSIGN_BITS-1:0] ic_req_pcsign,
    input  logic [LADDR_BITS-1:0]  ic_req_laddr,
    input  logic [SPTBR_BITS-1:0]  ic_req_sptbr,
    input  logic                   dc_req_valid,
    output logic                   dc_req_retry,
    input  logic [DCID_BITS-1:0]   dc_req_dcid,
    input  logic [CMD_BITS-1:0]    dc_req_cmd,
    input  logic [PCSIGN_BITS-1:0] dc_req_pcsign,
    input  logic [LADDR_BITS-1:0]  dc_req_laddr,
    input  logic [SPTBR_BITS-1:0]  dc_req_sptbr,
    output logic                   l1tol2_req_valid,
    input  logic                   l1tol2_req_retry,
    output logic                   l1tol2_req_src,
    output logic [DCID_BITS-1:0]   l1tol2_req_dcid,
    output logic [CMD_BITS-1:0]    l1tol2_req_cmd,
    output logic [PCSIGN_BITS-1:0] l1tol2_req_pcsign,
    output logic [LADDR_BITS-1:0]  l1tol2_req_laddr,
    output logic [SPTBR_BITS-1:0]  l1tol2_req_sptbr
);
    localparam int REQ_BITS = DCID_BITS + CMD_BITS + PCSIGN_BITS + LADDR_BITS + SPTBR_BITS;

    logic                ic_full, ic_empty, dc_full, dc_empty;
    logic [REQ_BITS-1:0] ic_head, dc_head;
    logic                load_en, any_ready, winner, ic_pop, dc_pop;
    logic                out_valid, out_src, last_grant;
    logic [REQ_BITS-1:0] out_data;

    l1tol2_req_arb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_BITS(REQ_BITS)) u_ic_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(ic_req_valid),
        .push_data ({ic_req_dcid, ic_req_cmd, ic_req_pcsign, ic_req_laddr, ic_req_sptbr}),
        .pop       (ic_pop),
        .full      (ic_full),
        .empty     (ic_empty),
        .head_data (ic_head)
    );

    l1tol2_req_arb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_BITS(REQ_BITS)) u_dc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(dc_req_valid),
        .push_data ({dc_req_dcid, dc_req_cmd, dc_req_pcsign, dc_req_laddr, dc_req_sptbr}),
        .pop       (dc_pop),
        .full      (dc_full),
        .empty     (dc_empty),
        .head_data (dc_head)
    );

    assign ic_req_retry = ic_full;
    assign dc_req_retry = dc_full;

    // winner: 0 = icache, 1 = dcache; on a tie the source that did not win last time goes next.
    always_comb begin
        load_en   = !out_valid || !l1tol2_req_retry;
        any_ready = !ic_empty || !dc_empty;
        if (!ic_empty && !dc_empty) begin
            winner = !last_grant;
        end else begin
            winner = !dc_empty;
        end
        ic_pop = load_en && any_ready && !winner;
        dc_pop = load_en && any_ready && winner;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_src    <= 1'b0;
            out_data   <= '0;
            last_grant <= 1'b0;
        end else if (load_en) begin
            if (any_ready) begin
                out_valid  <= 1'b1;
                out_src    <= winner;
                out_data   <= winner ? dc_head : ic_head;
                last_grant <= winner;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign l1tol2_req_valid = out_valid;
    assign l1tol2_req_src   = out_src;
    assign {l1tol2_req_dcid, l1tol2_req_cmd, l1tol2_req_pcsign,
            l1tol2_req_laddr, l1tol2_req_sptbr} = out_data;
endmodule

// File: doc/l1tol2_req_arb.md
Name: l1tol2_req_arb

Overview:
- Upstream feeder for the L2 cache request pipe.
- Merges the icache and dcache L1 request streams into the single l1tol2_req port of the L2 pipe, using valid/retry handshakes on both sides.
- Each L1 source has its own small request FIFO. A round-robin arbiter picks between the two FIFO heads and loads a registered output stage.
- Decouples L1 backpressure from L2 pipe stalls.

Parameters:
- FIFO_DEPTH, 2: entries per source FIFO; power of two, minimum 2.
- DCID_BITS, 5: width of the L1 request id.
- CMD_BITS, 4: width of the command.
- PCSIGN_BITS, 13: width of the PC signature.
- LADDR_BITS, 39: width of the line address.
- SPTBR_BITS, 38: width of the page-table base.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  icache request valid.
- ic_req_retry  out  1  icache must hold its request this cycle.
- ic_req_dcid / ic_req_cmd / ic_req_pcsign / ic_req_laddr / ic_req_sptbr  in  parameter widths  icache request fields.
- dc_req_valid  in  1  dcache request valid.
- dc_req_retry  out  1  dcache must hold its request this cycle.
- dc_req_dcid / dc_req_cmd / dc_req_pcsign / dc_req_laddr / dc_req_sptbr  in  parameter widths  dcache request fields.
- l1tol2_req_valid  out  1  request presented to the L2 pipe.
- l1tol2_req_retry  in  1  L2 pipe not accepting this cycle.
- l1tol2_req_src  out  1  source of the request: 0 = icache, 1 = dcache.
- l1tol2_req_dcid / l1tol2_req_cmd / l1tol2_req_pcsign / l1tol2_req_laddr / l1tol2_req_sptbr  out  parameter widths  request fields passed to the L2 pipe.

Behaviour:
- Handshake:
  - A transfer happens on a rising edge where valid=1 and retry=0.
  - A sender holds valid and all fields stable while retry=1.
  - Retry may be asserted while valid=0; it has no effect then.
- Input side:
  - x_req_retry = FIFO_x full. This is a function of registered state only; there is no combinational path from x_req_valid.
  - A full FIFO is never written, even if it is popped in the same cycle. Retry stays 1 that cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- FIFOs:
  - Circular buffer with wr_ptr/rd_ptr that wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH; empty when count=0, full when count=FIFO_DEPTH.
  - Requests leave each FIFO in the order they entered.
- Output stage:
  - Registers out_valid, src and all fields.
  - "Load-enable" = !out_valid OR (out_valid AND !l1tol2_req_retry).
  - When load-enable is 1 and at least one FIFO is non-empty: pop the winner's head into the output register and set out_valid=1.
  - When load-enable is 1 and both FIFOs are empty: out_valid goes to 0.
  - When load-enable is 0: output register holds.
- Arbitration:
  - A 1-bit last_grant register.
  - Only one FIFO non-empty: that FIFO wins.
  - Both non-empty: the source not equal to last_grant wins.
  - last_grant updates to the winner on every pop.
- Latency: a request accepted at edge N is visible on l1tol2_req_* after edge N+1, provided the output stage is free and it wins arbitration. No bypass path.
- Throughput: one request per cycle sustained while the L2 pipe does not retry.
- Reset (asynchronous, active-low):
  - All FIFO counts and pointers = 0.
  - out_valid = 0, so l1tol2_req_valid = 0.
  - l1tol2_req_src = 0 and all output fields = 0.
  - ic_req_retry = dc_req_retry = 0.
  - last_grant = 0 (icache), so dcache wins the first tie.
  - Reset asserted mid-operation drops all buffered requests; L1 senders re-issue after reset.
- Out of scope: no reordering, no merging of same-laddr requests, no command decoding. Fields pass through bit-exact.

Test Plan:
- Reset release, idle inputs -> l1tol2_req_valid=0 and both retries=0 every cycle.
- Single dcache request (dcid=3, cmd=1, laddr=0x12345) accepted at edge N, l1tol2_req_retry=0 -> valid=1, src=1, identical fields after edge N+1, valid=0 the following cycle.
- Both sources issue 4 back-to-back requests each, no L2 retry -> output order dc0, ic0, dc1, ic1, dc2, ic2, dc3, ic3; one per cycle after fill.
- L2 holds retry=1 for 6 cycles while icache streams (FIFO_DEPTH=2) -> output held stable; ic_req_retry rises once both entries are used; no loss or duplication after retry drops; icache ids are seen in order.
- FIFO full with a pop in the same cycle plus a new icache push -> push rejected (ic_req_retry=1 that cycle); the request is accepted on the next edge; pointer wrap yields correct order across more than 8 requests.
- reset pulled low while 3 requests are buffered and out_valid=1 -> l1tol2_req_valid=0 immediately (asynchronous); after release, buffered requests never appear on the output.
